// File: rtl/seq_tx_1101.sv
// rtl/seq_tx_1101.sv - framed serial transmitter: 1101 preamble, MSB-first payload, zero gap
module seq_tx_1101 #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             busy,
    output logic             sync_out,
    output logic             frame_done
);

    localparam int CMAX_WG = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CMAX    = (CMAX_WG > 4) ? CMAX_WG : 4;
    localparam int CW      = $clog2(CMAX);

    localparam logic [CW-1:0] PRE_LAST  = CW'(3);
    localparam logic [CW-1:0] PRE_ZERO  = CW'(2);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             w_nx;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
            w     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
            w     <= w_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        w_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (load) begin
                    state_nx = S_PRE;
                    cnt_nx   = '0;
                    shreg_nx = data_in;
                end
            end
            S_PRE: begin
                if (cnt == PRE_LAST) begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                shreg_nx = shreg << 1;
                if (cnt == DATA_LAST) begin
                    state_nx = S_GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // w is registered: derive it from where the FSM will be next cycle
        case (state_nx)
            S_PRE:   w_nx = (cnt_nx != PRE_ZERO);
            S_DATA:  w_nx = shreg_nx[WIDTH-1];
            default: w_nx = 1'b0;
        endcase
    end

    assign ready      = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign sync_out   = (state == S_PRE) && (cnt == PRE_LAST);
    assign frame_done = (state == S_GAP) && (cnt == GAP_LAST);

endmodule
